// File: rtl/adc_frame_sequencer_pkg.sv
// Shared definitions for the BlackPearl pixel readout sequencer.
//   seq_state_t  : sequencer phase (IDLE, RST, SMP, CNV, OUT)
//   DEF_T_RST    : default number of cycles S1 is held high per pixel
//   DEF_T_SAMPLE : default number of cycles S2bar is held low per pixel
//   addr_width() : width of the pixel index bus for a given pixel count
package bp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SMP,
        CNV,
        OUT
    } seq_state_t;

    localparam int unsigned DEF_T_RST    = 8;
    localparam int unsigned DEF_T_SAMPLE = 8;

    function automatic int unsigned addr_width(input int unsigned n_pix);
        return (n_pix <= 2) ? 1 : $clog2(n_pix);
    endfunction

endpackage

// File: rtl/adc_frame_sequencer_if.sv
// Pixel result stream between the sequencer and its downstream consumer.
//   pix_valid : result valid (master -> slave)
//   pix_ready : consumer accepts (slave -> master)
//   pix_data  : captured conversion code
//   pix_sat   : no comparator trip, code saturated
//   pix_addr  : pixel index within the frame
interface adc_frame_sequencer_if
    import bp_seq_pkg::*;
#(
    parameter int unsigned ADC_BITS = 4,
    parameter int unsigned ADDR_W   = addr_width(64)
);
    logic                pix_valid;
    logic                pix_ready;
    logic [ADC_BITS-1:0] pix_data;
    logic                pix_sat;
    logic [ADDR_W-1:0]   pix_addr;

    modport master (
        output pix_valid, pix_data, pix_sat, pix_addr,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_sat, pix_addr,
        output pix_ready
    );
endinterface

// File: rtl/adc_frame_sequencer_phase_timer.sv
// Loadable down-counter timing the RST and SMP phases.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   count      : current remaining count
//   done       : count has reached zero (last cycle of the phase)
module seq_phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/adc_frame_sequencer.sv
// Per-pixel readout sequencer: pixel reset, sample, single-slope conversion,
// then hand-off of the captured code on a valid/ready stream.
//   clk, reset           : clock, synchronous active-high reset
//   start_i              : frame start request (honoured in IDLE only)
//   abort_i              : synchronous abort back to IDLE
//   cont_i               : continuous mode, sampled at the last pixel's handshake
//   comp_i               : comparator, 1 = ramp crossed pixel level
//   S1, S2bar, S3        : pixel reset / sample (active-low) / readout switches
//   ramp_en, ramp_clr    : ramp generator enable and clear pulse
//   busy, eof            : not idle; one-cycle end-of-frame pulse
//   pix                  : result stream (valid/ready, data, sat, addr)
module adc_frame_sequencer
    import bp_seq_pkg::*;
#(
    parameter int unsigned N_PIX    = 64,
    parameter int unsigned ADC_BITS = 4,
    parameter int unsigned T_RST    = DEF_T_RST,
    parameter int unsigned T_SAMPLE = DEF_T_SAMPLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  cont_i,
    input  logic                  comp_i,
    output logic                  S1,
    output logic                  S2bar,
    output logic                  S3,
    output logic                  ramp_en,
    output logic                  ramp_clr,
    output logic                  busy,
    output logic                  eof,
    adc_frame_sequencer_if.master pix
);

    localparam int unsigned AW   = addr_width(N_PIX);
    localparam int unsigned TMAX = (T_RST > T_SAMPLE) ? T_RST : T_SAMPLE;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0]       RST_LOAD  = TW'(T_RST - 1);
    localparam logic [TW-1:0]       SMP_LOAD  = TW'(T_SAMPLE - 1);
    localparam logic [ADC_BITS-1:0] CODE_MAX  = '1;
    localparam logic [AW-1:0]       LAST_ADDR = AW'(N_PIX - 1);

    seq_state_t          state;
    logic [ADC_BITS-1:0] code;
    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic [TW-1:0]       tmr_count;
    logic                tmr_done;
    logic                handshake;
    logic                last_pix;

    assign handshake = pix.pix_valid & pix.pix_ready;
    assign last_pix  = (pix.pix_addr == LAST_ADDR);

    // The timer is loaded in the cycle before a timed phase is entered, so it
    // reads length-1 on the first cycle of the phase and zero on the last.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = RST_LOAD;
        if (!abort_i) begin
            case (state)
                IDLE: tmr_load = start_i;
                RST: begin
                    if (tmr_done) begin
                        tmr_load = 1'b1;
                        tmr_val  = SMP_LOAD;
                    end
                end
                OUT:     tmr_load = handshake && (!last_pix || cont_i);
                default: tmr_load = 1'b0;
            endcase
        end
    end

    seq_phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset || abort_i) begin
            state         <= IDLE;
            code          <= '0;
            S1            <= 1'b0;
            S2bar         <= 1'b1;
            S3            <= 1'b0;
            ramp_en       <= 1'b0;
            ramp_clr      <= 1'b0;
            busy          <= 1'b0;
            eof           <= 1'b0;
            pix.pix_valid <= 1'b0;
            pix.pix_data  <= '0;
            pix.pix_sat   <= 1'b0;
            pix.pix_addr  <= '0;
        end else begin
            eof <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= RST;
                        S1           <= 1'b1;
                        busy         <= 1'b1;
                        pix.pix_addr <= '0;
                    end
                end
                RST: begin
                    if (tmr_done) begin
                        state    <= SMP;
                        S1       <= 1'b0;
                        S2bar    <= 1'b0;
                        ramp_clr <= (T_SAMPLE == 1);
                    end
                end
                SMP: begin
                    if (tmr_done) begin
                        state    <= CNV;
                        S2bar    <= 1'b1;
                        ramp_clr <= 1'b0;
                        S3       <= 1'b1;
                        ramp_en  <= 1'b1;
                        code     <= '0;
                    end else begin
                        // Registered output: raise the clear one cycle early so
                        // it lands on the final SMP cycle.
                        ramp_clr <= (tmr_count == TW'(1));
                    end
                end
                CNV: begin
                    if (comp_i || (code == CODE_MAX)) begin
                        state         <= OUT;
                        S3            <= 1'b0;
                        ramp_en       <= 1'b0;
                        pix.pix_valid <= 1'b1;
                        pix.pix_data  <= code;
                        pix.pix_sat   <= ~comp_i;
                    end else begin
                        code <= code + ADC_BITS'(1);
                    end
                end
                OUT: begin
                    if (handshake) begin
                        pix.pix_valid <= 1'b0;
                        if (!last_pix) begin
                            pix.pix_addr <= pix.pix_addr + AW'(1);
                            state        <= RST;
                            S1           <= 1'b1;
                        end else begin
                            eof          <= 1'b1;
                            pix.pix_addr <= '0;
                            pix.pix_data <= '0;
                            pix.pix_sat  <= 1'b0;
                            if (cont_i) begin
                                state <= RST;
                                S1    <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Self-checking bench for adc_frame_sequencer (N_PIX=4, ADC_BITS=4, T_RST=8,
// T_SAMPLE=8). Expected per-cycle outputs come from a timeline model: each
// pixel is RST for T_RST cycles, SMP for T_SAMPLE cycles, CNV for
// min(trip+1, 16) cycles, then OUT until the ready handshake.
module tb_adc_frame_sequencer;

    localparam int NP   = 4;
    localparam int AB   = 4;
    localparam int TR   = 8;
    localparam int TS   = 8;
    localparam int MAXC = 15;
    localparam int NOTRIP = 16;

    // {S1,S2bar,S3,ramp_en,ramp_clr,valid,sat,busy,eof,data[3:0],addr[1:0]}
    localparam logic [14:0] IDLE_VEC = 15'h2000;
    localparam logic [14:0] EOF_VEC  = 15'h2040;

    logic clk = 1'b0;
    logic reset, start_i, abort_i, cont_i, comp_i;
    logic S1, S2bar, S3, ramp_en, ramp_clr, busy, eof;

    int n_cmp = 0;
    int n_bad = 0;

    adc_frame_sequencer_if #(.ADC_BITS(AB), .ADDR_W(2)) pix ();

    adc_frame_sequencer #(
        .N_PIX    (NP),
        .ADC_BITS (AB),
        .T_RST    (TR),
        .T_SAMPLE (TS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .cont_i   (cont_i),
        .comp_i   (comp_i),
        .S1       (S1),
        .S2bar    (S2bar),
        .S3       (S3),
        .ramp_en  (ramp_en),
        .ramp_clr (ramp_clr),
        .busy     (busy),
        .eof      (eof),
        .pix      (pix)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] snap();
        return {S1, S2bar, S3, ramp_en, ramp_clr, pix.pix_valid, pix.pix_sat,
                busy, eof, pix.pix_data, pix.pix_addr};
    endfunction

    task automatic start_frame();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Runs one pixel from its first RST cycle through the handshake, checking
    // every cycle against the timeline. trip = CNV cycle on which comp_i pulses
    // (NOTRIP = never). kill_at >= 0 applies abort (kind 1) or reset+start
    // (kind 2) at that cycle and returns one cycle later.
    task automatic do_pixel(input int trip, input int stall, input int addr,
                            input bit eof0, input int kill_at, input int kill_kind);
        int a, cnv, t_end, exp_data;
        logic [7:0] ctl_exp, ctl_act;
        a        = TR + TS;
        cnv      = (trip <= MAXC) ? trip + 1 : MAXC + 1;
        exp_data = (trip <= MAXC) ? trip : MAXC;
        t_end    = a + cnv + stall;
        for (int t = 0; t <= t_end; t++) begin
            ctl_exp = {t < TR, !(t >= TR && t < a), (t >= a && t < a + cnv),
                       (t >= a && t < a + cnv), t == a - 1, t >= a + cnv,
                       1'b1, (t == 0) ? eof0 : 1'b0};
            ctl_act = {S1, S2bar, S3, ramp_en, ramp_clr, pix.pix_valid, busy, eof};
            n_cmp++;
            if (ctl_act !== ctl_exp) begin
                n_bad++;
                $display("FAIL ctl pix%0d t=%0d: got %b want %b (S1,S2b,S3,ren,rclr,vld,busy,eof)",
                         addr, t, ctl_act, ctl_exp);
            end
            n_cmp++;
            if (pix.pix_addr !== 2'(addr)) begin
                n_bad++;
                $display("FAIL addr pix%0d t=%0d: got %0d want %0d", addr, t, pix.pix_addr, addr);
            end
            if (t >= a + cnv) begin
                n_cmp++;
                if ({pix.pix_sat, pix.pix_data} !== {trip > MAXC, 4'(exp_data)}) begin
                    n_bad++;
                    $display("FAIL result pix%0d t=%0d: got sat=%b data=%0d want sat=%b data=%0d",
                             addr, t, pix.pix_sat, pix.pix_data, trip > MAXC, exp_data);
                end
            end
            if (t == kill_at) begin
                if (kill_kind == 1) begin
                    abort_i = 1'b1;
                end else begin
                    reset   = 1'b1;
                    start_i = 1'b1;
                end
                comp_i        = 1'b1;
                pix.pix_ready = 1'b1;
                @(negedge clk);
                abort_i       = 1'b0;
                comp_i        = 1'b0;
                pix.pix_ready = 1'b0;
                return;
            end
            comp_i = (t >= a && t < a + cnv) ? (t - a == trip) : 1'($urandom);
            if (t >= t_end)
                pix.pix_ready = 1'b1;
            else if (t < a + cnv)
                pix.pix_ready = 1'($urandom);
            else
                pix.pix_ready = 1'b0;
            @(negedge clk);
        end
        comp_i        = 1'b0;
        pix.pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; cont_i = 1'b0;
        comp_i = 1'b0; pix.pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (snap() !== IDLE_VEC) begin
                n_bad++;
                $display("FAIL reset_state cyc%0d: got %h want %h", i, snap(), IDLE_VEC);
            end
            if (i == 1) reset = 1'b0;
            comp_i = 1'($urandom);
            @(negedge clk);
        end
        comp_i = 1'b0;
    endtask

    task automatic test_defaults_frame();
        cont_i = 1'b0;
        start_frame();
        do_pixel(5, 0, 0, 1'b0, -1, 0);
        do_pixel(NOTRIP, 0, 1, 1'b0, -1, 0);
        do_pixel(MAXC, 0, 2, 1'b0, -1, 0);
        do_pixel(3, 20, 3, 1'b0, -1, 0);
        n_cmp++;
        if (snap() !== EOF_VEC) begin
            n_bad++;
            $display("FAIL frame_end_eof: got %h want %h", snap(), EOF_VEC);
        end
        @(negedge clk);
        n_cmp++;
        if (snap() !== IDLE_VEC) begin
            n_bad++;
            $display("FAIL post_eof_idle: got %h want %h", snap(), IDLE_VEC);
        end
    endtask

    task automatic test_continuous();
        start_frame();
        for (int f = 0; f < 3; f++) begin
            cont_i = (f < 2);
            for (int p = 0; p < NP; p++)
                do_pixel(int'($urandom_range(0, NOTRIP)), int'($urandom_range(0, 3)),
                         p, (p == 0 && f > 0), -1, 0);
        end
        n_cmp++;
        if (snap() !== EOF_VEC) begin
            n_bad++;
            $display("FAIL cont_last_eof: got %h want %h", snap(), EOF_VEC);
        end
        @(negedge clk);
        cont_i = 1'b0;
    endtask

    task automatic test_abort();
        cont_i = 1'b0;
        start_frame();
        do_pixel(int'($urandom_range(0, NOTRIP)), 0, 0, 1'b0, -1, 0);
        do_pixel(int'($urandom_range(0, NOTRIP)), 1, 1, 1'b0, -1, 0);
        do_pixel(9, 0, 2, 1'b0, TR + TS + 2, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (snap() !== IDLE_VEC) begin
                n_bad++;
                $display("FAIL abort_cnv_idle cyc%0d: got %h want %h", i, snap(), IDLE_VEC);
            end
            @(negedge clk);
        end
        start_frame();
        do_pixel(2, 10, 0, 1'b0, TR + TS + 3 + 4, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (snap() !== IDLE_VEC) begin
                n_bad++;
                $display("FAIL abort_out_idle cyc%0d: got %h want %h", i, snap(), IDLE_VEC);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_smp();
        cont_i = 1'b0;
        start_frame();
        do_pixel(4, 0, 0, 1'b0, TR + 3, 2);
        n_cmp++;
        if (snap() !== IDLE_VEC) begin
            n_bad++;
            $display("FAIL reset_smp_idle: got %h want %h", snap(), IDLE_VEC);
        end
        @(negedge clk);
        n_cmp++;
        if (snap() !== IDLE_VEC) begin
            n_bad++;
            $display("FAIL reset_held_start_ignored: got %h want %h", snap(), IDLE_VEC);
        end
        reset = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        for (int p = 0; p < NP; p++)
            do_pixel(int'($urandom_range(0, NOTRIP)), int'($urandom_range(0, 2)),
                     p, 1'b0, -1, 0);
        n_cmp++;
        if (snap() !== EOF_VEC) begin
            n_bad++;
            $display("FAIL restart_frame_eof: got %h want %h", snap(), EOF_VEC);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_defaults_frame();
        test_continuous();
        test_abort();
        test_reset_mid_smp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Sequences per-pixel readout for the BlackPearl array: reset, sample, then single-slope conversion, repeated over N_PIX pixels per frame.
- Drives the pixel switch controls S1, S2bar and S3, plus the ramp enable and clear.
- Runs the conversion counter and captures the code when the comparator trips.
- Presents each result on a valid/ready interface and pulses eof at frame end.
- Sits between the central controller (start/abort/mode) and the ADC ramp/comparator.

Parameters:
N_PIX, 64, pixels per frame (≥2)
ADC_BITS, 4, conversion code width; full ramp = 2^ADC_BITS cycles
T_RST, 8, cycles S1 held high per pixel (≥1)
T_SAMPLE, 8, cycles S2bar held low per pixel (≥1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_i  in  1  one-cycle frame start request, honoured only in IDLE
abort_i  in  1  synchronous abort, any state
cont_i  in  1  continuous mode; sampled at the last pixel's handshake
comp_i  in  1  comparator output, 1 = ramp crossed pixel level
S1  out  1  pixel reset switch
S2bar  out  1  sample switch, active-low
S3  out  1  readout switch
ramp_en  out  1  analog ramp enable
ramp_clr  out  1  ramp clear pulse
pix_valid  out  1  result valid
pix_ready  in  1  downstream accepts
pix_data  out  ADC_BITS  captured code
pix_sat  out  1  no trip; code saturated
pix_addr  out  $clog2(N_PIX)  pixel index
busy  out  1  state != IDLE
eof  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset and IDLE output values: S1=0, S2bar=1, S3=0, ramp_en=0, ramp_clr=0, pix_valid=0, pix_sat=0, pix_data=0, pix_addr=0, busy=0, eof=0. All outputs are registered.
- State machine states: IDLE, RST, SMP, CNV, OUT.
- IDLE: start_i=1 → RST on the next cycle, pix_addr=0.
- RST: S1=1 for exactly T_RST cycles, then SMP.
- SMP: S2bar=0 for exactly T_SAMPLE cycles. ramp_clr=1 on the last SMP cycle only. Then CNV with code=0.
- CNV: S3=1 and ramp_en=1 every cycle; code increments each cycle.
  - comp_i=1 in a CNV cycle: capture the current code, pix_sat=0, go to OUT. A trip on cycle k gives pix_data=k, and CNV lasted k+1 cycles.
  - No trip through the cycle with code=2^ADC_BITS-1: capture 2^ADC_BITS-1, pix_sat=1, go to OUT.
  - A trip on the max-code cycle gives pix_sat=0.
  - comp_i is ignored outside CNV.
- OUT: pix_valid=1; pix_data, pix_sat and pix_addr are held stable until the handshake (pix_valid & pix_ready). The sequencer stalls indefinitely in OUT. S3=0, ramp_en=0.
- On handshake with pix_addr<N_PIX-1: pix_addr+1, go to RST next cycle.
- On handshake with pix_addr=N_PIX-1: eof=1 on the next cycle for one cycle. cont_i=1 → RST with pix_addr=0. cont_i=0 → IDLE.
- Pixel period with no stall: T_RST+T_SAMPLE+(CNV cycles)+1.
- abort_i=1 in any state: IDLE on the next cycle with all outputs at IDLE values. No eof. Any pending pix_valid is dropped. abort_i has priority over start_i and the handshake.
- start_i outside IDLE: ignored.
- reset overrides everything, including mid-conversion and mid-OUT.
- Phase counters are loaded on state entry. pix_addr wraps only via the end-of-frame rule.

Decomposition:
- Shared package bp_seq_pkg:
  - state enum type seq_state_t {IDLE, RST, SMP, CNV, OUT}
  - default timing localparams DEF_T_RST=8, DEF_T_SAMPLE=8
  - function for the pix_addr width
- One sub-module: seq_phase_timer, a loadable down-counter with a done flag, used for the RST and SMP durations.
- The conversion counter and FSM stay in the top module.

Test Plan:
- Defaults, start_i pulse, comp_i=1 on the 6th CNV cycle, pix_ready=1 → S1 high 8 cycles, S2bar low 8 cycles, ramp_clr on SMP cycle 8, pix_data=5, pix_sat=0, pix_addr=0; next pixel RST starts the cycle after the handshake.
- comp_i held 0 → CNV lasts 16 cycles, pix_data=15, pix_sat=1. comp_i rising exactly on the 16th cycle → pix_data=15, pix_sat=0.
- pix_ready held 0 for 20 cycles in OUT → pix_valid, data and addr stable for all 20 cycles, no switch activity, state advances only after the ready handshake.
- Full frame with N_PIX=4, cont_i=0 → addrs 0,1,2,3 in order, single eof pulse after the 4th handshake, busy=0 afterwards. Repeat with cont_i=1 → pix_addr returns to 0 with no IDLE cycle.
- abort_i in the 3rd CNV cycle, and separately during OUT → IDLE next cycle, all outputs at reset values, no eof; a later start_i begins again at pix_addr=0.
- reset asserted mid-SMP with start_i high simultaneously → IDLE outputs next cycle; start_i is honoured only after reset deasserts.
